user_wb_splitter: RTL and testbench
===================================

// Module: user_wb_splitter
// PURPOSE
//  Parametrised Wishbone classic splitter for the user project area. One upstream slave
//  port from the management SoC fans out to NUM_SLAVES downstream peripherals, such as the
//  CAN controller or the game registers. It adds registered decode, a per-access timeout,
//  sticky error flags, a status register window and an interrupt.
//  It replaces the single hard-wired peripheral hookup.
// PARAMETERS
//  NUM_SLAVES  4             downstream ports, 1..14
//  SLOT_LSB    16            lowest address bit of the 4-bit slot field wbs_adr_i[SLOT_LSB+3:SLOT_LSB]
//  TIMEOUT     255           cycles m_stb may stay high without ack before abort, 2..2**TO_W-1
//  TO_W        8             timeout counter width
//  ERR_DATA    32'hDEAD_C0DE read data returned on decode error or timeout
// PORTS
//  wb_clk_i   in   1        single clock, all logic rising-edge
//  wb_rst_i   in   1        synchronous, active-high reset
//  wbs_cyc_i  in   1        upstream cycle
//  wbs_stb_i  in   1        upstream strobe
//  wbs_we_i   in   1        upstream write enable
//  wbs_sel_i  in   4        byte selects
//  wbs_adr_i  in   32       byte address
//  wbs_dat_i  in   32       write data
//  wbs_ack_o  out  1        upstream ack, one-cycle pulse
//  wbs_dat_o  out  32       read data, valid while wbs_ack_o=1
//  m_cyc_o    out  NS       per-slave cycle (NS=NUM_SLAVES), one-hot or zero
//  m_stb_o    out  NS       per-slave strobe, equal to m_cyc_o
//  m_we_o     out  1        shared latched we
//  m_sel_o    out  4        shared latched sel
//  m_adr_o    out  32       shared latched address
//  m_dat_o    out  32       shared latched write data
//  m_dat_i    in   32*NS    slave read data; slave k uses bits [32k+31:32k]
//  m_ack_i    in   NS       slave acks; bits of non-selected slaves are ignored
//  irq_o      out  1        level: |(err_flags & irq_en)
// BEHAVIOUR
//  Reset: state=IDLE, all outputs 0, err_flags=0, irq_en=0, last_err_adr=0, txn_cnt=0.
//   Reset wins over every other event, including mid-transaction; no ack is issued for an aborted access.
//  FSM states: IDLE, FWD, RESP.
//  IDLE, on wbs_cyc_i&wbs_stb_i: latch adr/dat/we/sel into m_*_o; slot=adr[SLOT_LSB+3:SLOT_LSB].
//   slot<NS: assert m_cyc_o[slot]/m_stb_o[slot], clear the counter, go to FWD.
//   slot==15: local register access; go to RESP next cycle.
//   any other slot: decode error; set err_flags[31], rdata=ERR_DATA, go to RESP.
//  FWD: counter increments each cycle.
//   m_ack_i[slot]=1: capture m_dat_i slice, drop m_cyc/m_stb next edge, go to RESP.
//   No ack and counter==TIMEOUT-1: abort, so m_stb is high for exactly TIMEOUT cycles.
//    Drop m_cyc/m_stb, set err_flags[slot], last_err_adr=latched adr, rdata=ERR_DATA, go to RESP.
//   Ack and timeout in the same cycle: the ack wins and no flag is set.
//  RESP: wbs_ack_o=1 and wbs_dat_o=rdata for exactly 1 cycle; txn_cnt++ (32-bit, wraps); go to IDLE.
//   wbs_dat_o=0 whenever wbs_ack_o=0.
//   IDLE may accept a new request on the cycle after RESP.
//  Latency: zero-wait slave acks in the first FWD cycle -> wbs_ack_o two cycles after acceptance.
//  Writes always complete with ack even on error; write data is discarded on error.
//  Local regs (slot 15, word offset adr[3:2]):
//   0 err_flags, RW1C, bits [NS-1:0] plus bit31
//   1 irq_en, RW
//   2 last_err_adr, RO
//   3 txn_cnt, RO
//   Writes to RO regs are ignored. A flag set and a W1C clear in the same cycle: the set wins.
//   wbs_sel_i is ignored for local regs.
// TESTING
//  Read slot 1 with slave1 acking on the 1st m_stb cycle, data 32'h1234_5678
//   -> wbs_ack_o 2 cycles after acceptance, wbs_dat_o=32'h1234_5678; txn_cnt=1.
//  Write slot 2 with adr=32'h3002_0004, dat=32'hA5A5_0000, sel=4'b1100
//   -> only m_stb_o[2] high; m_adr_o/m_dat_o/m_sel_o match; m_ack_i[0] pulses are ignored.
//  Slot 3 never acks
//   -> m_stb_o[3] high for 255 cycles, then ack with 32'hDEAD_C0DE; err_flags=32'h8;
//   -> last_err_adr is correct; irq_o=1 after writing irq_en=32'h8.
//  Access slot 9 -> immediate ack with ERR_DATA and err_flags[31] set.
//   Write 32'h8000_0000 to offset 0 -> bit31 clears.
//  Assert wb_rst_i in the middle of FWD -> next cycle all m_* and wbs_ack_o are 0, state IDLE,
//   flags 0; a new read succeeds.
//  Slave ack on the same cycle as the timeout -> real data returned; err_flags unchanged.

Source files
------------

// File: rtl/user_wb_splitter.sv
`default_nettype none
// ============================================================================
// Module   : user_wb_splitter
// Brief    : Wishbone classic 1-to-N splitter with registered slot decode,
//            per-access timeout, sticky error flags, local status registers
//            and a level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module user_wb_splitter #(
    parameter int          NUM_SLAVES = 4,
    parameter int          SLOT_LSB   = 16,
    parameter int          TIMEOUT    = 255,
    parameter int          TO_W       = 8,
    parameter logic [31:0] ERR_DATA   = 32'hDEAD_C0DE
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    input  logic                      wbs_cyc_i,
    input  logic                      wbs_stb_i,
    input  logic                      wbs_we_i,
    input  logic [3:0]                wbs_sel_i,
    input  logic [31:0]               wbs_adr_i,
    input  logic [31:0]               wbs_dat_i,
    output logic                      wbs_ack_o,
    output logic [31:0]               wbs_dat_o,
    output logic [NUM_SLAVES-1:0]     m_cyc_o,
    output logic [NUM_SLAVES-1:0]     m_stb_o,
    output logic                      m_we_o,
    output logic [3:0]                m_sel_o,
    output logic [31:0]               m_adr_o,
    output logic [31:0]               m_dat_o,
    input  logic [32*NUM_SLAVES-1:0]  m_dat_i,
    input  logic [NUM_SLAVES-1:0]     m_ack_i,
    output logic                      irq_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    localparam logic [3:0]      c_local_slot = 4'hF;
    localparam logic [TO_W-1:0] c_to_last    = TO_W'(TIMEOUT - 1);
    localparam logic [31:0]     c_flag_mask  = 32'h8000_0000 | ((32'd1 << NUM_SLAVES) - 32'd1);

    state_t                  r_state;
    logic [NUM_SLAVES-1:0]   r_m_cyc;
    logic                    r_m_we;
    logic [3:0]              r_m_sel;
    logic [31:0]             r_m_adr;
    logic [31:0]             r_m_dat;
    logic [TO_W-1:0]         r_cnt;
    logic                    r_ack;
    logic [31:0]             r_rdata;
    logic [31:0]             r_err_flags;
    logic [31:0]             r_irq_en;
    logic [31:0]             r_last_err_adr;
    logic [31:0]             r_txn_cnt;

    logic [3:0]              w_slot;
    logic [1:0]              w_word;
    logic                    w_req;
    logic [NUM_SLAVES-1:0]   w_slot_oh;
    logic                    w_is_slave;
    logic                    w_is_local;
    logic                    w_dec_err;
    logic                    w_loc_wr;
    logic [31:0]             w_loc_rdata;
    logic                    w_ack;
    logic [31:0]             w_slave_rdata;
    logic                    w_timeout;
    logic [31:0]             w_err_set;
    logic [31:0]             w_err_clr;

    assign w_slot     = wbs_adr_i[SLOT_LSB+3:SLOT_LSB];
    assign w_word     = wbs_adr_i[3:2];
    assign w_req      = (r_state == S_IDLE) && wbs_cyc_i && wbs_stb_i;
    assign w_is_slave = |w_slot_oh;
    assign w_is_local = (w_slot == c_local_slot);
    assign w_dec_err  = w_req && !w_is_slave && !w_is_local;
    assign w_loc_wr   = w_req && w_is_local && wbs_we_i;

    always_comb begin
        w_slot_oh = '0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            w_slot_oh[k] = (w_slot == 4'(k));
        end
    end

    always_comb begin
        w_loc_rdata = 32'd0;
        case (w_word)
            2'd0:    w_loc_rdata = r_err_flags;
            2'd1:    w_loc_rdata = r_irq_en;
            2'd2:    w_loc_rdata = r_last_err_adr;
            default: w_loc_rdata = r_txn_cnt;
        endcase
    end

    // r_m_cyc is one-hot while forwarding, so it doubles as the ack/data select.
    assign w_ack = |(m_ack_i & r_m_cyc);

    always_comb begin
        w_slave_rdata = 32'd0;
        for (int k = 0; k < NUM_SLAVES; k++) begin
            w_slave_rdata = w_slave_rdata | (m_dat_i[32*k +: 32] & {32{r_m_cyc[k]}});
        end
    end

    assign w_timeout = (r_state == S_FWD) && !w_ack && (r_cnt == c_to_last);

    // Set terms are OR-ed after the clear so a simultaneous set survives a W1C.
    assign w_err_set = (w_timeout ? 32'(r_m_cyc) : 32'd0)
                     | (w_dec_err ? 32'h8000_0000 : 32'd0);
    assign w_err_clr = (w_loc_wr && (w_word == 2'd0)) ? (wbs_dat_i & c_flag_mask) : 32'd0;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state        <= S_IDLE;
            r_m_cyc        <= '0;
            r_m_we         <= 1'b0;
            r_m_sel        <= 4'd0;
            r_m_adr        <= 32'd0;
            r_m_dat        <= 32'd0;
            r_cnt          <= '0;
            r_ack          <= 1'b0;
            r_rdata        <= 32'd0;
            r_err_flags    <= 32'd0;
            r_irq_en       <= 32'd0;
            r_last_err_adr <= 32'd0;
            r_txn_cnt      <= 32'd0;
        end else begin
            r_err_flags <= (r_err_flags & ~w_err_clr) | w_err_set;
            if (w_loc_wr && (w_word == 2'd1)) begin
                r_irq_en <= wbs_dat_i;
            end

            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_m_we  <= wbs_we_i;
                        r_m_sel <= wbs_sel_i;
                        r_m_adr <= wbs_adr_i;
                        r_m_dat <= wbs_dat_i;
                        if (w_is_slave) begin
                            r_m_cyc <= w_slot_oh;
                            r_cnt   <= '0;
                            r_state <= S_FWD;
                        end else begin
                            r_ack   <= 1'b1;
                            r_rdata <= w_is_local ? w_loc_rdata : ERR_DATA;
                            r_state <= S_RESP;
                        end
                    end
                end
                S_FWD: begin
                    if (w_ack) begin
                        r_m_cyc <= '0;
                        r_ack   <= 1'b1;
                        r_rdata <= w_slave_rdata;
                        r_state <= S_RESP;
                    end else if (w_timeout) begin
                        r_m_cyc        <= '0;
                        r_ack          <= 1'b1;
                        r_rdata        <= ERR_DATA;
                        r_last_err_adr <= r_m_adr;
                        r_state        <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    r_ack     <= 1'b0;
                    r_rdata   <= 32'd0;
                    r_txn_cnt <= r_txn_cnt + 32'd1;
                    r_state   <= S_IDLE;
                end
                default: begin
                    r_m_cyc <= '0;
                    r_ack   <= 1'b0;
                    r_rdata <= 32'd0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_rdata;
    assign m_cyc_o   = r_m_cyc;
    assign m_stb_o   = r_m_cyc;
    assign m_we_o    = r_m_we;
    assign m_sel_o   = r_m_sel;
    assign m_adr_o   = r_m_adr;
    assign m_dat_o   = r_m_dat;
    assign irq_o     = |(r_err_flags & r_irq_en);

endmodule
`default_nettype wire

// File: tb/tb_user_wb_splitter.sv
`default_nettype none
// ============================================================================
// Module   : tb_user_wb_splitter
// Brief    : Transaction-level model and per-cycle compare for user_wb_splitter.
// Revision : 1.0 - initial release
// ============================================================================
module tb_user_wb_splitter;

    localparam int          NS    = 4;
    localparam int          TO    = 255;
    localparam logic [31:0] ERRD  = 32'hDEAD_C0DE;
    localparam logic [31:0] FMASK = 32'h8000_000F;

    logic                 clk = 1'b0;
    logic                 wb_rst_i = 1'b1;
    logic                 wbs_cyc_i = 1'b0;
    logic                 wbs_stb_i = 1'b0;
    logic                 wbs_we_i = 1'b0;
    logic [3:0]           wbs_sel_i = 4'd0;
    logic [31:0]          wbs_adr_i = 32'd0;
    logic [31:0]          wbs_dat_i = 32'd0;
    logic                 wbs_ack_o;
    logic [31:0]          wbs_dat_o;
    logic [NS-1:0]        m_cyc_o;
    logic [NS-1:0]        m_stb_o;
    logic                 m_we_o;
    logic [3:0]           m_sel_o;
    logic [31:0]          m_adr_o;
    logic [31:0]          m_dat_o;
    logic [32*NS-1:0]     m_dat_i = '0;
    logic [NS-1:0]        m_ack_i = '0;
    logic                 irq_o;

    user_wb_splitter #(
        .NUM_SLAVES (NS),
        .SLOT_LSB   (16),
        .TIMEOUT    (TO),
        .TO_W       (8),
        .ERR_DATA   (ERRD)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (wb_rst_i),
        .wbs_cyc_i (wbs_cyc_i),
        .wbs_stb_i (wbs_stb_i),
        .wbs_we_i  (wbs_we_i),
        .wbs_sel_i (wbs_sel_i),
        .wbs_adr_i (wbs_adr_i),
        .wbs_dat_i (wbs_dat_i),
        .wbs_ack_o (wbs_ack_o),
        .wbs_dat_o (wbs_dat_o),
        .m_cyc_o   (m_cyc_o),
        .m_stb_o   (m_stb_o),
        .m_we_o    (m_we_o),
        .m_sel_o   (m_sel_o),
        .m_adr_o   (m_adr_o),
        .m_dat_o   (m_dat_o),
        .m_dat_i   (m_dat_i),
        .m_ack_i   (m_ack_i),
        .irq_o     (irq_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    // Current transaction expectation: strobe window, ack cycle, data
    int            e_t0 = -10;
    int            e_nstb = 0;
    int            e_ack = -1;
    int            e_zero = -1;
    logic [NS-1:0] e_oh = '0;
    logic [31:0]   e_data = 32'd0;
    bit            e_chk_dat = 1'b0;
    logic [31:0]   e_adr = 32'd0;
    logic [31:0]   e_wdat = 32'd0;
    logic [3:0]    e_sel = 4'd0;
    logic          e_we = 1'b0;

    // Architectural register model
    logic [31:0]   md_flags = 32'd0;
    logic [31:0]   md_irq_en = 32'd0;
    logic [31:0]   md_last = 32'd0;
    logic [31:0]   md_cnt = 32'd0;

    // Slave responder plan
    logic [NS-1:0] p_oh = '0;
    int            p_slot = 0;
    int            p_ack_at = -1;
    logic [31:0]   p_dat = 32'd0;

    int            stb3_cnt = 0;
    bit            c_win;
    bit            c_ack;
    logic [NS-1:0] c_stb;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_stb_o[3] === 1'b1) stb3_cnt++;
        if (chk_en) begin
            c_win = (cyc >= e_t0 + 1) && (cyc <= e_t0 + e_nstb);
            c_stb = c_win ? e_oh : '0;
            c_ack = (cyc == e_ack);
            chk("m_stb_o", 32'(m_stb_o), 32'(c_stb));
            chk("m_cyc_o", 32'(m_cyc_o), 32'(c_stb));
            chk("wbs_ack_o", 32'(wbs_ack_o), 32'(c_ack));
            if (!c_ack) chk("wbs_dat_o_idle", wbs_dat_o, 32'd0);
            else if (e_chk_dat) chk("wbs_dat_o", wbs_dat_o, e_data);
            chk("irq_o", 32'(irq_o), 32'(|(md_flags & md_irq_en)));
            if (c_win) begin
                chk("m_adr_o", m_adr_o, e_adr);
                chk("m_dat_o", m_dat_o, e_wdat);
                chk("m_sel_o", 32'(m_sel_o), 32'(e_sel));
                chk("m_we_o", 32'(m_we_o), 32'(e_we));
            end
            if (cyc == e_zero) begin
                chk("rst_m_adr_o", m_adr_o, 32'd0);
                chk("rst_m_dat_o", m_dat_o, 32'd0);
                chk("rst_m_sel_o", 32'(m_sel_o), 32'd0);
                chk("rst_m_we_o", 32'(m_we_o), 32'd0);
            end
        end
    end

    // Advance one cycle and drive slave responses; non-selected acks are noise.
    task automatic tick();
        @(posedge clk);
        #1;
        m_ack_i = NS'($urandom) & ~p_oh;
        for (int k = 0; k < NS; k++) m_dat_i[32*k +: 32] = $urandom;
        if (cyc == p_ack_at) begin
            m_ack_i = m_ack_i | p_oh;
            m_dat_i[32*p_slot +: 32] = p_dat;
        end
    endtask

    function automatic logic [31:0] loc_rd(input logic [1:0] off);
        case (off)
            2'd0:    return md_flags;
            2'd1:    return md_irq_en;
            2'd2:    return md_last;
            default: return md_cnt;
        endcase
    endfunction

    // lat: stb cycle (1-based) in which the slave acks; 0 means never.
    task automatic do_txn(input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                          input logic [3:0] sel, input int lat, input logic [31:0] sdat,
                          output logic [31:0] got);
        int slot;
        bit tmo;
        slot = int'(adr[19:16]);
        tmo  = 1'b0;
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = we;
        wbs_sel_i = sel;  wbs_adr_i = adr;  wbs_dat_i = wdat;
        e_t0 = cyc; e_adr = adr; e_wdat = wdat; e_sel = sel; e_we = we;
        if (slot < NS) begin
            tmo       = (lat < 1) || (lat > TO);
            e_nstb    = tmo ? TO : lat;
            e_oh      = '0;
            e_oh[slot] = 1'b1;
            e_ack     = e_t0 + 1 + e_nstb;
            e_data    = tmo ? ERRD : sdat;
            e_chk_dat = tmo || !we;
            p_oh = e_oh; p_slot = slot; p_dat = sdat;
            p_ack_at = tmo ? -1 : e_t0 + lat;
        end else begin
            e_nstb = 0; e_oh = '0; e_ack = e_t0 + 1;
            if (slot == 15) begin
                e_data = loc_rd(adr[3:2]); e_chk_dat = !we;
            end else begin
                e_data = ERRD; e_chk_dat = 1'b1;
            end
        end
        while (cyc < e_ack) tick();
        got = wbs_dat_o;
        if (slot < NS) begin
            if (tmo) begin
                md_flags[slot] = 1'b1;
                md_last = adr;
            end
        end else if (slot == 15) begin
            if (we && adr[3:2] == 2'd0) md_flags = md_flags & ~(wdat & FMASK);
            if (we && adr[3:2] == 2'd1) md_irq_en = wdat;
        end else begin
            md_flags[31] = 1'b1;
        end
        tick();
        md_cnt = md_cnt + 32'd1;
        wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        p_oh = '0; p_ack_at = -1;
    endtask

    task automatic reset_mid(input int slot, input int hold);
        wbs_cyc_i = 1'b1; wbs_stb_i = 1'b1; wbs_we_i = 1'b0; wbs_sel_i = 4'hF;
        wbs_adr_i = 32'h3000_0000 | (32'(slot) << 16); wbs_dat_i = 32'd0;
        e_t0 = cyc; e_adr = wbs_adr_i; e_wdat = 32'd0; e_sel = 4'hF; e_we = 1'b0;
        e_nstb = TO; e_oh = '0; e_oh[slot] = 1'b1; e_ack = -1; e_chk_dat = 1'b0;
        p_oh = e_oh; p_slot = slot; p_ack_at = -1;
        repeat (hold) tick();
        wb_rst_i = 1'b1; wbs_cyc_i = 1'b0; wbs_stb_i = 1'b0;
        e_nstb = cyc - e_t0;
        tick();
        wb_rst_i = 1'b0;
        e_zero = cyc;
        md_flags = 32'd0; md_irq_en = 32'd0; md_last = 32'd0; md_cnt = 32'd0;
        p_oh = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] got;
        int s0;
        int slot;
        int r;
        int lat;
        logic [31:0] adr;

        repeat (3) @(posedge clk);
        #1;
        wb_rst_i = 1'b0;
        e_zero = cyc;
        chk_en = 1'b1;
        tick();

        do_txn(1'b0, 32'h3001_0000, 32'd0, 4'hF, 1, 32'h1234_5678, got);
        chk("lit_slot1_data", got, 32'h1234_5678);
        chk("lit_slot1_latency", 32'(e_ack - e_t0), 32'd2);
        do_txn(1'b0, 32'h300F_000C, 32'd0, 4'hF, 0, 32'd0, got);
        chk("lit_txn_cnt", got, 32'd1);

        do_txn(1'b1, 32'h3002_0004, 32'hA5A5_0000, 4'b1100, 3, 32'h0, got);

        s0 = stb3_cnt;
        do_txn(1'b0, 32'h3003_0010, 32'd0, 4'hF, 0, 32'd0, got);
        chk("lit_stb3_cycles", 32'(stb3_cnt - s0), 32'd255);
        chk("lit_timeout_data", got, 32'hDEAD_C0DE);
        do_txn(1'b0, 32'h300F_0000, 32'd0, 4'hF, 0, 32'd0, got);
        chk("lit_flags_to", got, 32'h0000_0008);
        do_txn(1'b0, 32'h300F_0008, 32'd0, 4'hF, 0, 32'd0, got);
        chk("lit_last_err_adr", got, 32'h3003_0010);
        do_txn(1'b1, 32'h300F_0004, 32'h0000_0008, 4'hF, 0, 32'd0, got);
        chk("lit_irq_on", 32'(irq_o), 32'd1);

        do_txn(1'b0, 32'h3009_0000, 32'd0, 4'hF, 0, 32'd0, got);
        chk("lit_dec_err_data", got, 32'hDEAD_C0DE);
        do_txn(1'b0, 32'h300F_0000, 32'd0, 4'hF, 0, 32'd0, got);
        chk("lit_flags_dec", got, 32'h8000_0008);
        do_txn(1'b1, 32'h300F_0000, 32'h8000_0000, 4'h0, 0, 32'd0, got);
        do_txn(1'b0, 32'h300F_0000, 32'd0, 4'hF, 0, 32'd0, got);
        chk("lit_flags_w1c", got, 32'h0000_0008);

        do_txn(1'b0, 32'h3000_0000, 32'd0, 4'hF, 255, 32'h0BAD_F00D, got);
        chk("lit_ack_at_timeout", got, 32'h0BAD_F00D);
        do_txn(1'b0, 32'h300F_0000, 32'd0, 4'hF, 0, 32'd0, got);
        chk("lit_flags_unchanged", got, 32'h0000_0008);

        reset_mid(1, 10);
        chk("lit_irq_after_rst", 32'(irq_o), 32'd0);
        do_txn(1'b0, 32'h300F_0000, 32'd0, 4'hF, 0, 32'd0, got);
        chk("lit_flags_after_rst", got, 32'd0);
        do_txn(1'b0, 32'h3001_0000, 32'd0, 4'hF, 2, 32'hCAFE_0001, got);
        chk("lit_read_after_rst", got, 32'hCAFE_0001);

        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 60)      slot = $urandom_range(0, NS - 1);
            else if (r < 85) slot = 15;
            else             slot = $urandom_range(NS, 14);
            r = $urandom_range(0, 99);
            if (r < 88)      lat = $urandom_range(1, 4);
            else if (r < 93) lat = 0;
            else if (r < 96) lat = TO;
            else             lat = $urandom_range(5, 20);
            adr = ($urandom & 32'hFFF0_FFFF) | (32'(slot) << 16);
            do_txn(1'($urandom_range(0, 1)), adr, $urandom, 4'($urandom), lat, $urandom, got);
            repeat ($urandom_range(0, 2)) tick();
        end

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
